multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Main control FSM for the multi-cycle RV32I core variant. Sequences the shared ALU, memory and
//  register file across FETCH/DECODE/EXECUTE/MEM/WB steps. Drives Imm_src to Sign_Extend,
//  mux selects, write enables and the memory request handshake. Also stalls on memory wait states.
// PARAMETERS
//  MEM_TIMEOUT  16  cycles waiting for mem_ready before asserting err and returning to FETCH
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous, active-high reset
//  Ins        in   32  current instruction register contents (opcode Ins[6:0], funct3 Ins[14:12])
//  Zero       in   1   ALU zero flag, valid in BEQ/BNE state
//  mem_ready  in   1   memory completes the current access this cycle
//  mem_req    out  1   memory access request, held until mem_ready
//  MemWrite   out  1   store strobe, qualifies mem_req
//  AdrSrc     out  1   0 = PC, 1 = ALUResult register drives memory address
//  IRWrite    out  1   load IR/OldPC
//  PCWrite    out  1   PC update (PCUpdate | Branch&cond)
//  RegWrite   out  1   register-file write enable
//  ALUSrcA    out  2   0 = PC, 1 = OldPC, 2 = RD1 register
//  ALUSrcB    out  2   0 = RD2 register, 1 = ImmExt, 2 = constant 4
//  ALUOp      out  2   0 = add, 1 = sub (branch), 2 = decode from funct3/funct7
//  ResultSrc  out  2   0 = ALUOut, 1 = Data register, 2 = ALUResult
//  Imm_src    out  3   immediate format to Sign_Extend (`Ext_ImmI/S/B/U/J)
//  err        out  1   one-cycle pulse: illegal opcode or memory timeout
// BEHAVIOUR
//  - States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, JAL, LUI.
//  - Reset: state = FETCH. All enables (mem_req, MemWrite, IRWrite, PCWrite, RegWrite, err) = 0.
//    Selects = 0, Imm_src = `Ext_ImmI. Outputs are Moore, decoded from state (PCWrite also uses Zero).
//  - FETCH: mem_req=1, AdrSrc=0. Hold until mem_ready. On mem_ready: IRWrite=1, PCWrite=1
//    (PC+4: ALUSrcA=0, ALUSrcB=2, ALUOp=0, ResultSrc=2), then DECODE. No PC/IR change while waiting.
//  - DECODE: ALUSrcA=1, ALUSrcB=1, ALUOp=0 (branch/jal target precompute). Imm_src from opcode:
//    load/op-imm/jalr->I, store->S, branch->B, lui/auipc->U, jal->J. Next state by opcode:
//    0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH, 1101111->JAL,
//    0110111->LUI. Any other opcode -> err pulse, then FETCH with no architectural write.
//  - MEMADR: ALUSrcA=2, ALUSrcB=1, ALUOp=0. Next is MEMRD for a load, MEMWR for a store.
//  - MEMRD: mem_req=1, AdrSrc=1; waits on mem_ready, then MEMWB. MEMWB: ResultSrc=1, RegWrite=1 -> FETCH.
//  - MEMWR: mem_req=1, MemWrite=1, AdrSrc=1; waits on mem_ready, then FETCH.
//  - EXECR: ALUSrcA=2, ALUSrcB=0, ALUOp=2. EXECI: ALUSrcB=1 with otherwise the same settings.
//    Both go to ALUWB. ALUWB: ResultSrc=0, RegWrite=1 -> FETCH.
//  - BRANCH: ALUSrcA=2, ALUSrcB=0, ALUOp=1, ResultSrc=0. PCWrite = Zero^funct3[0]
//    (beq/bne only) -> FETCH.
//  - JAL: ALUSrcA=1, ALUSrcB=2, ResultSrc=0, PCWrite=1 -> ALUWB (rd = OldPC+4).
//  - LUI: ALUSrcA=2 forced-zero path not available; use ALUSrcB=1 with ALUOp=0 on x0.
//    ALUSrcA=2 with Ins[19:15] masked by datapath -> ALUWB.
//  - Wait counter: 5-bit, cleared on every state entry, counts while mem_req & !mem_ready.
//    At MEM_TIMEOUT-1: err pulse, drop mem_req, go to FETCH. No RegWrite/PCWrite occurs.
//  - mem_ready while mem_req=0 is ignored. mem_req never deasserts before mem_ready/timeout.
//  - rst mid-access: next cycle FETCH with mem_req=0 and counter cleared. A pending store is abandoned.
// STRUCTURE
//  - Shared defines file (the existing one holding `Ext_Imm*`): Ext_ImmI=0, S=1, B=2, U=3, J=4.
//    It also holds the opcode constants OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_LUI,
//    the state encodings, and the ALUOp/ResultSrc/ALUSrc codes.
//  - Sub-module imm_src_dec (opcode -> Imm_src, combinational), reused by the single-cycle core.
// TESTING
//  - rst=1 for 2 cycles -> state FETCH, all enables 0. First cycle after rst: mem_req=1, AdrSrc=0.
//  - add (0x002081B3), mem_ready immediate -> FETCH,DECODE,EXECR,ALUWB. RegWrite=1 only in cycle 4.
//  - lw (0x0000A103), mem_ready delayed 3 cycles in MEMRD -> mem_req held 4 cycles.
//    Then MEMWB with ResultSrc=1 and RegWrite=1. Imm_src=0 in DECODE.
//  - beq (0x00208463): Zero=1 -> PCWrite=1 in BRANCH. Zero=0 -> PCWrite=0. Imm_src=2 in DECODE.
//  - sw with mem_ready never asserted -> err pulse on cycle 16 of MEMWR, then FETCH.
//    MemWrite drops and no RegWrite occurs.
//  - opcode 0x7F -> err pulse in DECODE, then FETCH. Also assert rst during MEMRD wait -> FETCH next cycle.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multi-cycle RV32I control path:
// immediate formats, opcodes, FSM states and datapath select codes.
package multicycle_ctrl_pkg;

    // Immediate format codes driven to Sign_Extend
    localparam logic [2:0] EXT_IMM_I = 3'd0;
    localparam logic [2:0] EXT_IMM_S = 3'd1;
    localparam logic [2:0] EXT_IMM_B = 3'd2;
    localparam logic [2:0] EXT_IMM_U = 3'd3;
    localparam logic [2:0] EXT_IMM_J = 3'd4;

    // Major opcodes (Ins[6:0])
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_LUI
    } state_t;

    // ALUSrcA
    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RD1   = 2'd2;
    // ALUSrcB
    localparam logic [1:0] SRCB_RD2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;
    // ALUOp
    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;
    // ResultSrc
    localparam logic [1:0] RES_ALUOUT    = 2'd0;
    localparam logic [1:0] RES_DATA      = 2'd1;
    localparam logic [1:0] RES_ALURESULT = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_imm_src_dec.sv
// imm_src_dec: opcode -> immediate format select (combinational).
// Ports: opcode [6:0] in, imm_src [2:0] out. Unknown opcodes map to I.
module imm_src_dec
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] imm_src
);

    always_comb begin
        imm_src = EXT_IMM_I;
        case (opcode)
            OP_LOAD, OP_I, OP_JALR: imm_src = EXT_IMM_I;
            OP_STORE:               imm_src = EXT_IMM_S;
            OP_BR:                  imm_src = EXT_IMM_B;
            OP_LUI, OP_AUIPC:       imm_src = EXT_IMM_U;
            OP_JAL:                 imm_src = EXT_IMM_J;
            default:                imm_src = EXT_IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main FSM of the multi-cycle RV32I core. Sequences
// fetch/decode/execute/mem/writeback, drives datapath selects and write
// enables, and runs the memory request handshake with a wait timeout.
// Ports: clk, rst (sync, active-high); Ins, Zero, mem_ready in;
// mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA/B,
// ALUOp, ResultSrc, Imm_src, err out.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Ins,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  ResultSrc,
    output logic [2:0]  Imm_src,
    output logic        err
);

    localparam logic [4:0] CNT_LAST = 5'(MEM_TIMEOUT - 1);

    state_t     state, state_next;
    logic [4:0] cnt, cnt_next;
    logic       timeout;
    logic [2:0] imm_dec;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_ins;

    assign opcode     = Ins[6:0];
    assign funct3     = Ins[14:12];
    assign unused_ins = ^{Ins[31:15], Ins[11:7]};

    imm_src_dec u_imm_src_dec (
        .opcode  (opcode),
        .imm_src (imm_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        timeout    = 1'b0;
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RD2;
        ALUOp      = ALU_ADD;
        ResultSrc  = RES_ALUOUT;
        Imm_src    = imm_dec;
        err        = 1'b0;

        unique case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                if (mem_ready) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = S_DECODE;
                end else if (cnt == CNT_LAST) begin
                    timeout = 1'b1;
                end
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_R:              state_next = S_EXECR;
                    OP_I:              state_next = S_EXECI;
                    OP_BR:             state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_LUI:            state_next = S_LUI;
                    default: begin
                        err        = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                state_next = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) begin
                    state_next = S_MEMWB;
                end else if (cnt == CNT_LAST) begin
                    timeout = 1'b1;
                end
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                if (mem_ready) begin
                    state_next = S_FETCH;
                end else if (cnt == CNT_LAST) begin
                    timeout = 1'b1;
                end
            end
            S_EXECR, S_EXECI: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = (state == S_EXECI) ? SRCB_IMM : SRCB_RD2;
                ALUOp      = ALU_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_RD1;
                ALUOp      = ALU_SUB;
                // beq/bne only: funct3[0] inverts the sense of Zero
                PCWrite    = (funct3[2:1] == 2'b00) & (Zero ^ funct3[0]);
                state_next = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                PCWrite    = 1'b1;
                state_next = S_ALUWB;
            end
            S_LUI: begin
                // rs1 field is forced to x0 by the datapath: 0 + ImmExt
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                state_next = S_ALUWB;
            end
            default: state_next = S_FETCH;
        endcase

        // Timed-out access: drop the request and restart the fetch
        if (timeout) begin
            mem_req    = 1'b0;
            MemWrite   = 1'b0;
            err        = 1'b1;
            state_next = S_FETCH;
        end

        // Counter restarts on every state entry, including a FETCH retry
        if (timeout || state_next != state) begin
            cnt_next = '0;
        end else if (mem_req && !mem_ready) begin
            cnt_next = cnt + 5'd1;
        end else begin
            cnt_next = cnt;
        end

        if (rst) begin
            mem_req   = 1'b0;
            MemWrite  = 1'b0;
            AdrSrc    = 1'b0;
            IRWrite   = 1'b0;
            PCWrite   = 1'b0;
            RegWrite  = 1'b0;
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_RD2;
            ALUOp     = ALU_ADD;
            ResultSrc = RES_ALUOUT;
            Imm_src   = EXT_IMM_I;
            err       = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl: per-cycle control words
// compared against hand-computed values.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Ins;
    logic        Zero;
    logic        mem_ready;
    logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0]  ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
    logic [2:0]  Imm_src;
    logic        err;
    logic [17:0] ctl;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .Ins       (Ins),
        .Zero      (Zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .MemWrite  (MemWrite),
        .AdrSrc    (AdrSrc),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .RegWrite  (RegWrite),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .ResultSrc (ResultSrc),
        .Imm_src   (Imm_src),
        .err       (err)
    );

    assign ctl = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                  ALUSrcA, ALUSrcB, ALUOp, ResultSrc, Imm_src, err};

    // Packs hand-written field values into the control-word layout
    function automatic logic [17:0] mk(
        input logic req, mw, adr, irw, pcw, rw,
        input logic [1:0] sa, sb, op, rs,
        input logic [2:0] imm,
        input logic e
    );
        return {req, mw, adr, irw, pcw, rw, sa, sb, op, rs, imm, e};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic z);
        mem_ready = rdy;
        Zero      = z;
        #1;
    endtask

    // FETCH cycle with immediate mem_ready for instruction ins
    task automatic fetch(input string tag, input logic [31:0] ins,
                         input logic [2:0] imm);
        Ins = ins;
        drive(1'b1, 1'b0);
        check({tag, "_fetch"}, 32'(ctl), 32'(mk(1,0,0,1,1,0,0,2,0,2,imm,0)));
        tick();
        drive(1'b0, 1'b0);
        check({tag, "_decode"}, 32'(ctl), 32'(mk(0,0,0,0,0,0,1,1,0,0,imm,0)));
        tick();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; Ins = 32'h0; Zero = 1'b0; mem_ready = 1'b0;
        tick();
        tick();
        check("reset", 32'(ctl), 32'(mk(0,0,0,0,0,0,0,0,0,0,0,0)));
        rst = 1'b0;
        drive(1'b0, 1'b0);
        check("fetch_after_rst", 32'(ctl), 32'(mk(1,0,0,0,0,0,0,2,0,2,0,0)));
        tick();

        // add x3,x1,x2
        fetch("add", 32'h002081B3, 3'd0);
        drive(1'b0, 1'b0);
        check("add_execr", 32'(ctl), 32'(mk(0,0,0,0,0,0,2,0,2,0,0,0)));
        tick();
        check("add_aluwb", 32'(ctl), 32'(mk(0,0,0,0,0,1,0,0,0,0,0,0)));
        tick();

        // lw x2,0(x1) with three wait cycles
        fetch("lw", 32'h0000A103, 3'd0);
        check("lw_memadr", 32'(ctl), 32'(mk(0,0,0,0,0,0,2,1,0,0,0,0)));
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(i == 3, 1'b0);
            check("lw_memrd", 32'(ctl), 32'(mk(1,0,1,0,0,0,0,0,0,0,0,0)));
            tick();
        end
        drive(1'b0, 1'b0);
        check("lw_memwb", 32'(ctl), 32'(mk(0,0,0,0,0,1,0,0,0,1,0,0)));
        tick();

        // beq taken / not taken, bne with Zero=1
        fetch("beq_t", 32'h00208463, 3'd2);
        drive(1'b0, 1'b1);
        check("beq_taken", 32'(ctl), 32'(mk(0,0,0,0,1,0,2,0,1,0,2,0)));
        tick();
        fetch("beq_n", 32'h00208463, 3'd2);
        drive(1'b0, 1'b0);
        check("beq_not", 32'(ctl), 32'(mk(0,0,0,0,0,0,2,0,1,0,2,0)));
        tick();
        fetch("bne", 32'h00209463, 3'd2);
        drive(1'b0, 1'b1);
        check("bne_zero", 32'(ctl), 32'(mk(0,0,0,0,0,0,2,0,1,0,2,0)));
        tick();

        // addi, jal, lui
        fetch("addi", 32'h00100093, 3'd0);
        check("addi_execi", 32'(ctl), 32'(mk(0,0,0,0,0,0,2,1,2,0,0,0)));
        tick();
        check("addi_aluwb", 32'(ctl), 32'(mk(0,0,0,0,0,1,0,0,0,0,0,0)));
        tick();
        fetch("jal", 32'h008000EF, 3'd4);
        check("jal_state", 32'(ctl), 32'(mk(0,0,0,0,1,0,1,2,0,0,4,0)));
        tick();
        check("jal_aluwb", 32'(ctl), 32'(mk(0,0,0,0,0,1,0,0,0,0,4,0)));
        tick();
        fetch("lui", 32'h123450B7, 3'd3);
        check("lui_state", 32'(ctl), 32'(mk(0,0,0,0,0,0,2,1,0,0,3,0)));
        tick();
        check("lui_aluwb", 32'(ctl), 32'(mk(0,0,0,0,0,1,0,0,0,0,3,0)));
        tick();

        // sw with mem_ready never asserted: timeout on cycle 16
        fetch("sw", 32'h0020A023, 3'd1);
        check("sw_memadr", 32'(ctl), 32'(mk(0,0,0,0,0,0,2,1,0,0,1,0)));
        tick();
        for (int i = 1; i <= 15; i++) begin
            drive(1'b0, 1'b0);
            check("sw_memwr_wait", 32'(ctl), 32'(mk(1,1,1,0,0,0,0,0,0,0,1,0)));
            tick();
        end
        drive(1'b0, 1'b0);
        check("sw_timeout_err", 32'(err), 32'd1);
        check("sw_timeout_wr", 32'({MemWrite, RegWrite, PCWrite}), 32'd0);
        tick();
        check("sw_back_fetch", 32'(ctl), 32'(mk(1,0,0,0,0,0,0,2,0,2,1,0)));

        // illegal opcode 0x7F
        Ins = 32'h0000007F;
        drive(1'b1, 1'b0);
        check("ill_fetch", 32'(ctl), 32'(mk(1,0,0,1,1,0,0,2,0,2,0,0)));
        tick();
        drive(1'b0, 1'b0);
        check("ill_decode", 32'(ctl), 32'(mk(0,0,0,0,0,0,1,1,0,0,0,1)));
        tick();
        check("ill_fetch2", 32'(ctl), 32'(mk(1,0,0,0,0,0,0,2,0,2,0,0)));

        // reset during MEMRD wait, then a full FETCH timeout
        fetch("lw2", 32'h0000A103, 3'd0);
        tick();
        drive(1'b0, 1'b0);
        check("lw2_memrd", 32'(ctl), 32'(mk(1,0,1,0,0,0,0,0,0,0,0,0)));
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid_access", 32'(ctl), 32'(mk(0,0,0,0,0,0,0,0,0,0,0,0)));
        rst = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            drive(1'b0, 1'b0);
            if (i == 1)
                check("rst_fetch", 32'(ctl), 32'(mk(1,0,0,0,0,0,0,2,0,2,0,0)));
            check("fetch_wait_err", 32'(err), 32'd0);
            tick();
        end
        drive(1'b0, 1'b0);
        check("fetch_timeout_err", 32'(err), 32'd1);
        tick();
        check("fetch_retry", 32'(ctl), 32'(mk(1,0,0,0,0,0,0,2,0,2,0,0)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
